// File: rtl/pipe_skid_ctrl_if.sv
// Valid/ready handshake bundle for the two-entry skid stage.
// master drives the upstream/downstream controls, slave is the stage.
interface pipe_skid_ctrl_if #(
  parameter int WIDTH = 222
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             flush;
  logic [1:0]       occupancy;
  logic [15:0]      stall_count;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data,
    input  occupancy, stall_count
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data,
    output occupancy, stall_count
  );
endinterface

// File: rtl/pipe_skid_ctrl.sv
// Two-entry (main + skid) pipeline stage controller with flush
// and a saturating downstream stall counter.
module pipe_skid_ctrl #(
  parameter int WIDTH = 222
) (
  input logic             clk,
  input logic             reset,
  pipe_skid_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [15:0]      stall_q, stall_d;

  logic out_valid;
  logic accept;
  logic emit;

  assign out_valid = (state_q != EMPTY);
  assign accept    = bus.in_valid & in_ready_q;
  assign emit      = out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = bus.in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && emit) begin
          main_d = bus.in_data;
        end else if (accept) begin
          skid_d  = bus.in_data;
          state_d = FULL;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins; register contents are left as-is (don't-care).
    if (bus.flush) begin
      state_d = EMPTY;
    end
    in_ready_d = (state_d != FULL);
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !bus.out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      stall_q    <= stall_d;
    end
  end

  always_comb begin
    unique case (state_q)
      BUSY:    bus.occupancy = 2'd1;
      FULL:    bus.occupancy = 2'd2;
      default: bus.occupancy = 2'd0;
    endcase
  end

  assign bus.out_valid   = out_valid;
  assign bus.out_data    = main_q;
  assign bus.in_ready    = in_ready_q;
  assign bus.stall_count = stall_q;

endmodule

// File: tb/tb_pipe_skid_ctrl.sv
// Directed bench for pipe_skid_ctrl: queue-based reference model
// checked every cycle plus literal expectations at key points.
module tb_pipe_skid_ctrl;
  localparam int W = 222;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_skid_ctrl_if #(.WIDTH(W)) bus ();

  pipe_skid_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int passed = 0;
  int total  = 0;

  // Reference model: FIFO of held entries, capacity 2.
  logic [W-1:0] mq[$];
  logic         m_rdy = 1'b1;
  int           m_stall = 0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    bit acc, em;
    acc = bus.in_valid && m_rdy;
    em  = (mq.size() > 0) && bus.out_ready;
    if (reset) begin
      mq.delete();
      m_rdy   = 1'b1;
      m_stall = 0;
    end else begin
      if ((mq.size() > 0) && !bus.out_ready && m_stall < 65535)
        m_stall = m_stall + 1;
      if (bus.flush) begin
        mq.delete();
      end else begin
        if (em) void'(mq.pop_front());
        if (acc) mq.push_back(bus.in_data);
      end
      m_rdy = (mq.size() < 2);
    end
  end

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_occ", W'(bus.occupancy), W'(mq.size()));
      chk("m_ovalid", W'(bus.out_valid), W'(mq.size() > 0));
      chk("m_irdy", W'(bus.in_ready), W'(m_rdy));
      chk("m_stall", W'(bus.stall_count), W'(m_stall));
      if (mq.size() > 0) chk("m_odata", bus.out_data, mq[0]);
    end
  end

  task automatic cyc(input logic iv, input logic [W-1:0] d,
                     input logic ordy, input logic fl,
                     input logic rst);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
    reset         = rst;
    @(negedge clk);
  endtask

  logic [W-1:0] pa, pb, px, py;

  initial begin
    pa = {W{1'b1}} >> 3;
    pb = W'(222'h1234_5678_9ABC);
    px = W'(222'hDEAD);
    py = W'(222'hBEEF);
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    reset         = 1'b1;
    @(negedge clk);

    cyc(1, W'(8'h5A), 0, 0, 1);
    chk_en = 1'b1;
    cyc(1, W'(8'h5A), 0, 0, 1);
    chk("rst_irdy", W'(bus.in_ready), W'(1));
    chk("rst_ovalid", W'(bus.out_valid), W'(0));
    chk("rst_odata", bus.out_data, '0);
    chk("rst_occ", W'(bus.occupancy), W'(0));
    chk("rst_stall", W'(bus.stall_count), W'(0));

    // streaming
    for (int i = 1; i <= 3; i++) begin
      cyc(1, W'(i), 1, 0, 0);
      chk("str_odata", bus.out_data, W'(i));
      chk("str_occ", W'(bus.occupancy), W'(1));
      chk("str_irdy", W'(bus.in_ready), W'(1));
    end
    cyc(0, '0, 1, 0, 0);
    chk("str_drain", W'(bus.occupancy), W'(0));

    // backpressure
    cyc(1, pa, 0, 0, 0);
    chk("bp_occ1", W'(bus.occupancy), W'(1));
    chk("bp_irdy1", W'(bus.in_ready), W'(1));
    cyc(1, pb, 0, 0, 0);
    chk("bp_occ2", W'(bus.occupancy), W'(2));
    chk("bp_irdy0", W'(bus.in_ready), W'(0));
    for (int i = 0; i < 3; i++) cyc(1, W'(8'hCC), 0, 0, 0);
    chk("bp_odata", bus.out_data, pa);
    chk("bp_stall", W'(bus.stall_count), W'(4));
    cyc(0, '0, 1, 0, 0);
    chk("bp_odataB", bus.out_data, pb);
    chk("bp_irdy_rec", W'(bus.in_ready), W'(1));
    cyc(0, '0, 1, 0, 0);
    chk("bp_empty", W'(bus.out_valid), W'(0));

    // accept + emit in BUSY
    cyc(1, px, 0, 0, 0);
    cyc(1, py, 1, 0, 0);
    chk("ae_odata", bus.out_data, py);
    chk("ae_occ", W'(bus.occupancy), W'(1));

    // flush while FULL with in_valid and out_ready
    cyc(1, px, 0, 0, 0);
    chk("fl_full", W'(bus.occupancy), W'(2));
    cyc(1, W'(8'h77), 1, 1, 0);
    chk("fl_occ", W'(bus.occupancy), W'(0));
    chk("fl_ovalid", W'(bus.out_valid), W'(0));
    chk("fl_irdy", W'(bus.in_ready), W'(1));
    cyc(1, W'(8'h42), 1, 0, 0);
    chk("fl_newacc", bus.out_data, W'(8'h42));
    cyc(0, '0, 1, 0, 0);

    // stall saturation
    cyc(1, W'(8'h99), 0, 0, 0);
    for (int i = 0; i < 70000; i++) cyc(0, '0, 0, 0, 0);
    chk("sat_val", W'(bus.stall_count), W'(16'hFFFF));
    cyc(0, '0, 0, 1, 0);
    chk("sat_flush", W'(bus.stall_count), W'(16'hFFFF));
    chk("sat_flush_occ", W'(bus.occupancy), W'(0));
    cyc(0, '0, 0, 0, 1);
    chk("sat_reset", W'(bus.stall_count), W'(0));
    cyc(0, '0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
